// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scan driver with frame-aligned value commit.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    ready,
    output logic [2:0]              digit_idx,
    output logic [7:0]              AN,
    output logic [7:0]              CATHODES,
    output logic                    dbg_state_o
);

    localparam int          CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
    localparam logic [2:0]  LAST_IDX = 3'(NUM_DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic                    pend_q, pend_d;
    logic [7:0]              an_q, an_d;
    logic [7:0]              cath_q, cath_d;

    logic       tick;
    logic       frame_end;
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       cur_blank;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Handshake: a load is accepted on any rising edge where load=1 and ready=1;
    // ready drops while a value waits in the shadow for the next frame boundary.
    assign ready       = ~pend_q;
    assign digit_idx   = idx_q;
    assign AN          = an_q;
    assign CATHODES    = cath_q;
    assign dbg_state_o = state_q;

    assign tick      = (state_q == SCAN) && (cnt_q == LAST_CNT);
    assign frame_end = tick && (idx_q == LAST_IDX);

    // Active-register view of the digit currently being scanned.
    always_comb begin
        logic upper_zero;
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (act_val_q[4*k +: 4] == 4'h0);
            if (idx_q == 3'(k)) begin
                cur_nib = act_val_q[4*k +: 4];
                cur_dp  = act_dp_q[k];
`ifdef SEG_LZ_BLANK_EN
                cur_blank = upper_zero && (k != 0);
`else
                cur_blank = 1'b0;
`endif
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        sh_val_d  = sh_val_q;
        sh_dp_d   = sh_dp_q;
        pend_d    = pend_q;
        an_d      = 8'hFF;
        cath_d    = 8'hFF;

        case (state_q)
            BLANK: begin
                cnt_d = '0;
                if (load) begin
                    act_val_d = value;
                    act_dp_d  = dp_in;
                    idx_d     = 3'd0;
                    state_d   = SCAN;
                end
            end
            default: begin
                cnt_d = tick ? '0 : cnt_q + CW'(1);
                if (tick) begin
                    idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
                end
                // pend_q is sampled, so a load on the boundary edge waits a full frame.
                if (frame_end && pend_q) begin
                    act_val_d = sh_val_q;
                    act_dp_d  = sh_dp_q;
                    pend_d    = 1'b0;
                end else if (load && !pend_q) begin
                    sh_val_d = value;
                    sh_dp_d  = dp_in;
                    pend_d   = 1'b1;
                end
                an_d[idx_q] = 1'b0;
                cath_d      = {~cur_dp, cur_blank ? 7'h7F : seg7(cur_nib)};
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            pend_q    <= 1'b0;
            an_q      <= 8'hFF;
            cath_q    <= 8'hFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            pend_q    <= pend_d;
            an_q      <= an_d;
            cath_q    <= cath_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4); honours SEG_LZ_BLANK_EN.
module tb_seg_scan_driver;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        ready;
    logic [2:0]  digit_idx;
    logic [7:0]  an;
    logic [7:0]  cathodes;
    logic        dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

`ifdef SEG_LZ_BLANK_EN
    localparam logic [7:0] LZ0    = 8'hFF;
    localparam logic [7:0] LZ0_DP = 8'h7F;
`else
    localparam logic [7:0] LZ0    = 8'hC0;
    localparam logic [7:0] LZ0_DP = 8'h40;
`endif

    seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .ready       (ready),
        .digit_idx   (digit_idx),
        .AN          (an),
        .CATHODES    (cathodes),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_an"}, 32'(an), 32'hFF);
        check({tag, "_cath"}, 32'(cathodes), 32'hFF);
        check({tag, "_rdy"}, 32'(ready), 32'h1);
        check({tag, "_st"}, 32'(dbg_state), 32'h0);
    endtask

    task automatic check_slot(input string tag, input logic [7:0] an_e, input logic [7:0] cath_e,
                              input int n, input logic rdy_e);
        for (int i = 0; i < n; i++) begin
            check({tag, "_an"}, 32'(an), 32'(an_e));
            check({tag, "_cath"}, 32'(cathodes), 32'(cath_e));
            check({tag, "_rdy"}, 32'(ready), 32'(rdy_e));
            step();
        end
    endtask

    task automatic push_frame(input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3);
        exp_q.push_back({8'hFE, c0});
        exp_q.push_back({8'hFD, c1});
        exp_q.push_back({8'hFB, c2});
        exp_q.push_back({8'hF7, c3});
    endtask

    task automatic run_frame(input string tag, input logic rdy_e);
        logic [15:0] e;
        for (int s = 0; s < 4; s++) begin
            e = exp_q.pop_front();
            check_slot(tag, e[15:8], e[7:0], 4, rdy_e);
        end
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        dp_in = 4'h0;
        step();
        step();
        check_blank("rst");
        check("rst_idx", 32'(digit_idx), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            check_blank("idle");
            step();
        end

        // First load in BLANK: digit 0 lights two cycles after the load cycle.
        value = 16'h12AF;
        dp_in = 4'b0000;
        load  = 1'b1;
        step();
        load = 1'b0;
        check("blank_load_rdy", 32'(ready), 32'h1);
        check("blank_load_an", 32'(an), 32'hFF);
        step();
        push_frame(8'h8E, 8'h88, 8'hA4, 8'hF9);
        run_frame("f1", 1'b1);

        // Second frame: load 0008 at idx=1, then an ignored FFFF.
        check_slot("f2s0", 8'hFE, 8'h8E, 4, 1'b1);
        check("f2_idx", 32'(digit_idx), 32'h1);
        check("f2_an", 32'(an), 32'hFD);
        value = 16'h0008;
        load  = 1'b1;
        step();
        load = 1'b0;
        check("f2_rdy0", 32'(ready), 32'h0);
        check("f2_an1", 32'(an), 32'hFD);
        value = 16'hFFFF;
        load  = 1'b1;
        step();
        load = 1'b0;
        check_slot("f2s1", 8'hFD, 8'h88, 2, 1'b0);
        check_slot("f2s2", 8'hFB, 8'hA4, 4, 1'b0);
        check_slot("f2s3", 8'hF7, 8'hF9, 3, 1'b0);
        check_slot("f2s3c", 8'hF7, 8'hF9, 1, 1'b1);

        // Third frame shows 0008; load exactly on its boundary tick.
        check_slot("f3s0", 8'hFE, 8'h80, 4, 1'b1);
        check_slot("f3s1", 8'hFD, LZ0, 4, 1'b1);
        check_slot("f3s2", 8'hFB, LZ0, 4, 1'b1);
        check_slot("f3s3", 8'hF7, LZ0, 2, 1'b1);
        check("f3_idx", 32'(digit_idx), 32'h3);
        check("f3_rdy", 32'(ready), 32'h1);
        value = 16'h3456;
        dp_in = 4'b0101;
        load  = 1'b1;
        step();
        load = 1'b0;
        check("bnd_rdy0", 32'(ready), 32'h0);
        check("bnd_an", 32'(an), 32'hF7);
        check("bnd_cath", 32'(cathodes), 32'(LZ0));
        step();

        // Fourth frame still 0008; commit at its end.
        check_slot("f4s0", 8'hFE, 8'h80, 4, 1'b0);
        check_slot("f4s1", 8'hFD, LZ0, 4, 1'b0);
        check_slot("f4s2", 8'hFB, LZ0, 4, 1'b0);
        check_slot("f4s3", 8'hF7, LZ0, 3, 1'b0);
        check_slot("f4s3c", 8'hF7, LZ0, 1, 1'b1);

        push_frame(8'h02, 8'h92, 8'h19, 8'hB0);
        run_frame("f5", 1'b1);

        // Pending load then asynchronous reset mid-slot at idx=2.
        value = 16'h7777;
        dp_in = 4'b0000;
        load  = 1'b1;
        step();
        load = 1'b0;
        check("pend_rdy0", 32'(ready), 32'h0);
        for (int i = 0; i < 7; i++) step();
        check("pre_rst_idx", 32'(digit_idx), 32'h2);
        check("pre_rst_an", 32'(an), 32'hFB);
        reset = 1'b1;
        #1;
        check_blank("async_rst");
        check("async_rst_idx", 32'(digit_idx), 32'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check_blank("post_rst");
            step();
        end

        // All-zero value with dp on digit 3: digit 0 always shown.
        value = 16'h0000;
        dp_in = 4'b1000;
        load  = 1'b1;
        step();
        load = 1'b0;
        check("zero_rdy", 32'(ready), 32'h1);
        step();
        push_frame(8'hC0, LZ0, LZ0, LZ0_DP);
        run_frame("f7", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
